// File: rtl/fir_out_requant_if.sv
// Streaming bus between the FIR filter output and the requantiser.
//   in_valid / data_in / shift : incoming filter samples plus per-sample shift amount
//   out_ready                  : downstream backpressure
//   out_valid / data_out       : requantised result
// Modports: slave (the requantiser), master (the driving side / bench).
interface fir_out_requant_if #(
  parameter int unsigned IN_W  = 111,
  parameter int unsigned OUT_W = 16
) ();
  logic                    in_valid;
  logic signed [IN_W-1:0]  data_in;
  logic        [6:0]       shift;
  logic                    out_ready;
  logic                    out_valid;
  logic signed [OUT_W-1:0] data_out;

  modport slave (
    input  in_valid, data_in, shift, out_ready,
    output out_valid, data_out
  );

  modport master (
    output in_valid, data_in, shift, out_ready,
    input  out_valid, data_out
  );
endinterface

// File: rtl/fir_out_requant.sv
// Decimating output requantiser for a wide FIR filter.
// Keeps one valid sample in DECIM, rounds it down by a per-sample right shift and
// saturates it to OUT_W bits, presenting it on a valid/ready output register.
// Ports:
//   i_clk, i_rst   : clock and synchronous active-high reset
//   bus            : fir_out_requant_if.slave (input samples, shift, output handshake)
//   i_clear_flags  : clears the sticky flags
//   o_sat_flag     : sticky, a result was clamped
//   o_ovr_flag     : sticky, a result was dropped because the output was held
module fir_out_requant #(
  parameter int unsigned IN_W  = 111,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DECIM = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  fir_out_requant_if.slave       bus,
  input  logic                   i_clear_flags,
  output logic                   o_sat_flag,
  output logic                   o_ovr_flag
);

  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [6:0] MAX_SH = 7'(IN_W - 1);
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Decimation counter and keep decision
  logic [CNT_W-1:0] r_dcnt;
  logic             w_keep;
  assign w_keep = bus.in_valid && (r_dcnt == '0);

  // Stage 0: captured sample and its shift
  logic                   r_s0_valid;
  logic signed [IN_W-1:0] r_s0_data;
  logic [6:0]             r_s0_shift;

  // Stage 1: shift and round
  logic [6:0]             w_s;
  logic signed [IN_W:0]   w_ext;
  logic signed [IN_W:0]   w_shr;
  logic                   w_rnd;
  logic signed [IN_W:0]   w_rounded;
  logic                   r_s1_valid;
  logic signed [IN_W:0]   r_s1_val;

  assign w_s   = (r_s0_shift > MAX_SH) ? MAX_SH : r_s0_shift;
  assign w_ext = {r_s0_data[IN_W-1], r_s0_data};
  assign w_shr = w_ext >>> w_s;
  // Adding the last bit shifted out rounds halves toward +infinity
  assign w_rnd = (w_s != 7'd0) ? r_s0_data[w_s - 7'd1] : 1'b0;
  assign w_rounded = w_shr + {{IN_W{1'b0}}, w_rnd};

  // Stage 2: saturate into the output register
  logic                    w_sat_hi;
  logic                    w_sat_lo;
  logic signed [OUT_W-1:0] w_sat_val;
  logic                    w_load;
  logic                    w_drop;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_data_out;
  logic                    r_sat_flag;
  logic                    r_ovr_flag;

  assign w_sat_hi  = r_s1_val > SAT_MAX;
  assign w_sat_lo  = r_s1_val < SAT_MIN;
  assign w_sat_val = w_sat_hi ? SAT_MAX[OUT_W-1:0] :
                     w_sat_lo ? SAT_MIN[OUT_W-1:0] : r_s1_val[OUT_W-1:0];
  // Output register takes a new result when empty or being consumed this cycle
  assign w_load = r_s1_valid && (!r_out_valid || bus.out_ready);
  assign w_drop = r_s1_valid && r_out_valid && !bus.out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dcnt      <= '0;
      r_s0_valid  <= 1'b0;
      r_s0_data   <= '0;
      r_s0_shift  <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_val    <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_sat_flag  <= 1'b0;
      r_ovr_flag  <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        r_dcnt <= (r_dcnt == CNT_LAST) ? '0 : r_dcnt + CNT_W'(1);
      end

      r_s0_valid <= w_keep;
      if (w_keep) begin
        r_s0_data  <= bus.data_in;
        r_s0_shift <= bus.shift;
      end

      r_s1_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_s1_val <= w_rounded;
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_data_out  <= w_sat_val;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A set event in the same cycle wins over clear
      if (w_load && (w_sat_hi || w_sat_lo)) begin
        r_sat_flag <= 1'b1;
      end else if (i_clear_flags) begin
        r_sat_flag <= 1'b0;
      end

      if (w_drop) begin
        r_ovr_flag <= 1'b1;
      end else if (i_clear_flags) begin
        r_ovr_flag <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.data_out  = r_data_out;
  assign o_sat_flag    = r_sat_flag;
  assign o_ovr_flag    = r_ovr_flag;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: decimation, rounding, shift clamp, saturation,
// backpressure/overrun, reset mid-flight and shift change in flight.
module tb_fir_out_requant;

  localparam int unsigned IN_W  = 111;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned DECIM = 4;

  logic clk = 1'b0;
  logic rst;
  logic clear_flags;
  logic sat_flag;
  logic ovr_flag;

  int n_checks = 0;
  int n_fail   = 0;

  fir_out_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fir_out_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM(DECIM)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .i_clear_flags (clear_flags),
    .o_sat_flag    (sat_flag),
    .o_ovr_flag    (ovr_flag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [127:0] got,
                          input logic signed [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [IN_W-1:0] d, input logic [6:0] sh);
    bus.in_valid = v;
    bus.data_in  = d;
    bus.shift    = sh;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_flags = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, 7'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Keep one sample plus three unkept fillers so the counter returns to zero
  task automatic keep_only(input logic signed [IN_W-1:0] d, input logic [6:0] sh);
    drive(1'b1, d, sh);
    step();
    drive(1'b1, '0, 7'd0);
    step();
    step();
    step();
    drive(1'b0, '0, 7'd0);
  endtask

  // Keep one sample and check it three cycles later
  task automatic run_one(input string tag, input logic signed [IN_W-1:0] d,
                         input logic [6:0] sh, input logic signed [127:0] exp);
    drive(1'b1, d, sh);
    step();
    drive(1'b1, '0, 7'd0);
    step();
    step();
    check_eq({tag, "_valid"}, bus.out_valid, 1);
    check_eq(tag, bus.data_out, exp);
    step();
    drive(1'b0, '0, 7'd0);
  endtask

  logic signed [IN_W-1:0] p40;
  logic signed [IN_W-1:0] p109;

  initial begin
    p40 = '0;
    p40[40] = 1'b1;
    p109 = '0;
    p109[109] = 1'b1;

    // Reset state
    do_reset();
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_data_out", bus.data_out, 0);
    check_eq("rst_sat", sat_flag, 0);
    check_eq("rst_ovr", ovr_flag, 0);

    // Decimation by 4: inputs 1..9 give 1, 5, 9 three cycles later
    for (int c = 0; c < 14; c++) begin
      if (c == 3 || c == 7 || c == 11) begin
        check_eq($sformatf("dec_valid_c%0d", c), bus.out_valid, 1);
        check_eq($sformatf("dec_data_c%0d", c), bus.data_out, c - 2);
      end else begin
        check_eq($sformatf("dec_idle_c%0d", c), bus.out_valid, 0);
      end
      if (c < 9) drive(1'b1, IN_W'(c + 1), 7'd0);
      else       drive(1'b0, '0, 7'd0);
      step();
    end

    // Rounding with shift 8
    do_reset();
    run_one("rnd_p384", 384, 7'd8, 2);
    run_one("rnd_n384", -384, 7'd8, -1);
    run_one("rnd_p383", 383, 7'd8, 1);
    run_one("rnd_n385", -385, 7'd8, -2);

    // Shift clamped to IN_W-1
    run_one("clamp_n5", -5, 7'd127, 0);
    run_one("clamp_p109", p109, 7'd127, 1);

    // Saturation boundaries
    run_one("edge_max", 32767, 7'd0, 32767);
    run_one("edge_min", -32768, 7'd0, -32768);
    check_eq("edge_no_sat", sat_flag, 0);
    run_one("sat_32768", 32768, 7'd0, 32767);
    check_eq("sat_flag_a", sat_flag, 1);
    run_one("sat_p40", p40, 7'd8, 32767);
    run_one("sat_n40", -p40, 7'd8, -32768);
    check_eq("sat_flag_b", sat_flag, 1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check_eq("sat_cleared", sat_flag, 0);

    // Backpressure: 10 held, 20 dropped, overrun flagged
    do_reset();
    bus.out_ready = 1'b0;
    keep_only(10, 7'd0);
    check_eq("bp_hold_a", bus.data_out, 10);
    keep_only(20, 7'd0);
    check_eq("bp_valid", bus.out_valid, 1);
    check_eq("bp_hold_b", bus.data_out, 10);
    check_eq("bp_ovr", ovr_flag, 1);
    bus.out_ready = 1'b1;
    check_eq("bp_xfer_data", bus.data_out, 10);
    step();
    check_eq("bp_after_a", bus.out_valid, 0);
    step();
    check_eq("bp_after_b", bus.out_valid, 0);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check_eq("ovr_cleared", ovr_flag, 0);

    // Reset mid-flight discards the kept sample
    do_reset();
    drive(1'b1, 77, 7'd0);
    step();
    drive(1'b0, '0, 7'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_eq($sformatf("rst_flight_c%0d", c), bus.out_valid, 0);
      step();
    end
    run_one("rst_first", 33, 7'd0, 33);

    // Shift change right after the kept sample does not affect it
    run_one("shift_flight", 4096, 7'd4, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_out_requant.md
FIR_OUT_REQUANT -- requirements
Module: fir_out_requant

Interface
REQ-001 Parameter IN_W, default 111, width of the signed FIR filter output consumed by this block.
REQ-002 Parameter OUT_W, default 16, width of the signed requantised output sample.
REQ-003 Parameter DECIM, default 4, decimation ratio; legal range 1..256.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  qualifies data_in for the current cycle.
REQ-007 data_in  input  IN_W  signed two's-complement FIR filter output.
REQ-008 shift  input  7  right-shift amount, captured together with each kept sample.
REQ-009 out_ready  input  1  downstream accepts data_out this cycle.
REQ-010 clear_flags  input  1  clears sticky flags.
REQ-011 out_valid  output  1  data_out holds an unconsumed result.
REQ-012 data_out  output  OUT_W  signed requantised sample.
REQ-013 sat_flag  output  1  sticky: a kept result saturated.
REQ-014 ovr_flag  output  1  sticky: a result was dropped due to backpressure.

Function
REQ-015 The decimation counter dcnt (0..DECIM-1) shall advance on every cycle with in_valid=1 and wrap from DECIM-1 to 0; it shall hold when in_valid=0.
REQ-016 A sample shall be kept only when in_valid=1 and dcnt=0; the first valid sample after reset is therefore kept.
REQ-017 Stage 0 shall register each kept data_in and shift; a later change to shift shall not affect samples already in flight.
REQ-018 Shift clamp: an effective shift s = min(shift, IN_W-1).
REQ-019 Stage 1 shall compute an arithmetic right shift by s in IN_W+1 bits and add bit s-1 of the original value when s>0 (round half toward +infinity); with s=0 the value passes unchanged.
REQ-020 Stage 2 shall saturate the rounded value to OUT_W signed: above 2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1; below -2^(OUT_W-1) -> -2^(OUT_W-1); any clamp shall set sat_flag.
REQ-021 Latency: a sample kept in cycle N shall appear with out_valid=1 in cycle N+3, provided the output register is empty or consumed in cycle N+2.
REQ-022 Handshake: a transfer occurs in any cycle with out_valid=1 and out_ready=1; out_valid and data_out shall remain stable while out_valid=1 and out_ready=0.
REQ-023 A new result and a transfer in the same cycle shall load the new result, and out_valid shall stay 1.
REQ-024 A result arriving while out_valid=1 and out_ready=0 shall be discarded; data_out shall be unchanged and ovr_flag shall be set.
REQ-025 The pipeline shall never stall input; in_valid is accepted every cycle regardless of out_ready.
REQ-026 clear_flags shall zero both sticky flags the next cycle; a set event in the same cycle shall take priority, leaving that flag at 1.
REQ-027 DECIM=1 shall keep every valid sample.

Reset
REQ-028 While rst=1 at a clk edge: dcnt=0, all stage valids=0, out_valid=0, data_out=0, sat_flag=0, ovr_flag=0.
REQ-029 Reset asserted mid-operation shall discard all in-flight samples; no output shall emerge from pre-reset inputs.
REQ-030 The first kept sample after reset shall be the first in_valid cycle at or after the cycle in which rst is sampled low.

Verification
REQ-031 Decimation: DECIM=4, shift=0, out_ready=1, in_valid continuous, data_in=1,2,...,9 -> outputs 1, 5, 9, each 3 cycles after its input.
REQ-032 Rounding: shift=8 with data_in=384 -> 2; data_in=-384 -> -1; data_in=383 -> 1; data_in=-385 -> -2.
REQ-033 Saturation: shift=8 with data_in=2^40 -> 32767 and sat_flag=1; data_in=-2^40 -> -32768; clear_flags pulse -> sat_flag=0.
REQ-034 Backpressure: out_ready=0, two kept samples 10 then 20 (shift=0) -> data_out=10 is held and ovr_flag=1; raising out_ready gives a single transfer of 10, then out_valid=0.
REQ-035 Reset mid-flight: a kept sample followed by rst=1 in the next cycle -> out_valid stays 0; after release, DECIM=4 keeps the first valid sample.
REQ-036 Shift change in flight: sample 4096 kept with shift=4, then shift set to 0 the next cycle -> output 256.
